// File: rtl/memory_controller.sv
// Byte-serial memory controller: arbitrates the instruction fetcher and the load/store
// buffer onto a single-port 8-bit RAM bus, assembling little-endian words.
module memory_controller (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_to_mc_valid,
  input  logic [31:0] if_to_mc_PC,
  output logic        mc_to_if_ready,
  output logic [31:0] mc_to_if_inst,
  input  logic        lsb_to_mc_valid,
  input  logic        lsb_to_mc_wr,
  input  logic [1:0]  lsb_to_mc_len,
  input  logic [31:0] lsb_to_mc_addr,
  input  logic [31:0] lsb_to_mc_data,
  output logic        mc_to_lsb_ready,
  output logic [31:0] mc_to_lsb_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IFETCH = 2'd1,
    S_LOAD   = 2'd2,
    S_STORE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_ready_q, if_ready_d;
  logic        lsb_ready_q, lsb_ready_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] lsb_data_q, lsb_data_d;
  logic        frozen_q, frozen_d;
  logic [7:0]  din_hold_q, din_hold_d;

  logic        io_stall_s;
  logic        lsb_go_s;
  logic        if_go_s;
  logic [2:0]  cnt_inc_s;
  logic [7:0]  din_eff_s;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   len_to_n = 3'd1;
      2'b01:   len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [2:0] idx,
                                           input logic [7:0] b);
    put_byte = word;
    case (idx)
      3'd0:    put_byte[7:0]   = b;
      3'd1:    put_byte[15:8]  = b;
      3'd2:    put_byte[23:16] = b;
      3'd3:    put_byte[31:24] = b;
      default: put_byte = word;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [2:0] idx);
    case (idx)
      3'd0:    get_byte = word[7:0];
      3'd1:    get_byte = word[15:8];
      3'd2:    get_byte = word[23:16];
      3'd3:    get_byte = word[31:24];
      default: get_byte = 8'h00;
    endcase
  endfunction

  // A write into the IO window is held off combinationally while the IO buffer is full.
  assign io_stall_s = (state_q == S_STORE) && (mem_a_q[17:16] == 2'b11) && io_buffer_full;
  assign lsb_go_s   = lsb_to_mc_valid && !lsb_ready_q;
  assign if_go_s    = if_to_mc_valid && !if_ready_q && !clear_in;
  assign cnt_inc_s  = cnt_q + 3'd1;
  // After a freeze the RAM has already moved on to the held address; use the byte
  // captured on the first frozen cycle instead.
  assign din_eff_s  = frozen_q ? din_hold_q : mem_din;

  assign mem_a           = mem_a_q;
  assign mem_dout        = mem_dout_q;
  assign mem_wr          = mem_wr_q && rdy_in && !io_stall_s;
  assign mc_to_if_ready  = if_ready_q;
  assign mc_to_if_inst   = inst_q;
  assign mc_to_lsb_ready = lsb_ready_q;
  assign mc_to_lsb_data  = lsb_data_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_ready_d  = if_ready_q;
    lsb_ready_d = lsb_ready_q;
    inst_d      = inst_q;
    lsb_data_d  = lsb_data_q;
    frozen_d    = !rdy_in;
    din_hold_d  = din_hold_q;

    if (!rdy_in && !frozen_q) begin
      din_hold_d = mem_din;
    end else begin
      din_hold_d = din_hold_q;
    end

    if (rdy_in) begin
      if_ready_d  = 1'b0;
      lsb_ready_d = 1'b0;
      mem_wr_d    = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lsb_go_s) begin
            base_d  = lsb_to_mc_addr;
            n_d     = len_to_n(lsb_to_mc_len);
            cnt_d   = 3'd0;
            mem_a_d = lsb_to_mc_addr;
            if (lsb_to_mc_wr) begin
              state_d    = S_STORE;
              buf_d      = lsb_to_mc_data;
              mem_dout_d = lsb_to_mc_data[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d = S_LOAD;
              buf_d   = 32'h0000_0000;
            end
          end else if (if_go_s) begin
            state_d = S_IFETCH;
            base_d  = if_to_mc_PC;
            n_d     = 3'd4;
            cnt_d   = 3'd0;
            mem_a_d = if_to_mc_PC;
            buf_d   = 32'h0000_0000;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_IFETCH, S_LOAD: begin
          if ((state_q == S_IFETCH) && clear_in) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else begin
            // cnt counts addresses issued; byte cnt-1 is on mem_din this cycle.
            if (cnt_q != 3'd0) begin
              buf_d = put_byte(buf_q, cnt_q - 3'd1, din_eff_s);
            end else begin
              buf_d = buf_q;
            end
            if (cnt_q == n_q) begin
              state_d = S_IDLE;
              cnt_d   = 3'd0;
              if (state_q == S_IFETCH) begin
                if_ready_d = 1'b1;
                inst_d     = buf_d;
              end else begin
                lsb_ready_d = 1'b1;
                lsb_data_d  = buf_d;
              end
            end else begin
              cnt_d = cnt_inc_s;
              if (cnt_inc_s < n_q) begin
                mem_a_d = base_q + {29'd0, cnt_inc_s};
              end else begin
                mem_a_d = mem_a_q;
              end
            end
          end
        end
        S_STORE: begin
          if (io_stall_s) begin
            mem_wr_d = 1'b1;
          end else if (cnt_inc_s < n_q) begin
            cnt_d      = cnt_inc_s;
            mem_a_d    = base_q + {29'd0, cnt_inc_s};
            mem_dout_d = get_byte(buf_q, cnt_inc_s);
            mem_wr_d   = 1'b1;
          end else begin
            state_d     = S_IDLE;
            cnt_d       = 3'd0;
            lsb_ready_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      base_q      <= 32'h0000_0000;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      buf_q       <= 32'h0000_0000;
      mem_a_q     <= 32'h0000_0000;
      mem_dout_q  <= 8'h00;
      mem_wr_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      inst_q      <= 32'h0000_0000;
      lsb_data_q  <= 32'h0000_0000;
      frozen_q    <= 1'b0;
      din_hold_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_ready_q  <= if_ready_d;
      lsb_ready_q <= lsb_ready_d;
      inst_q      <= inst_d;
      lsb_data_q  <= lsb_data_d;
      frozen_q    <= frozen_d;
      din_hold_q  <= din_hold_d;
    end
  end

endmodule
